issue_scoreboard: RTL and testbench

//  Register scoreboard and issue controller between the ID stage and EX.
//  - Counts in-flight writes per GPR.
//  - Holds the decoded instruction in ID (stall_o) while a source or destination is unsafe.
//  - Releases each entry on writeback.
//  - sync_i drains the whole pipeline before issue resumes.

---
 rtl/issue_scoreboard.sv | 192 +++++++++++++++++++
 tb/tb_issue_scoreboard.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: register scoreboard and issue controller between ID and EX.
// Tracks in-flight GPR writes per register and in total, and holds the ID
// instruction on RAW hazards, per-register counter saturation or a full
// total counter. A sync request drains every pending write before the next
// issue.
// Optional build macro: ISSUE_SB_STATS_EN adds saturating stall and drain
// event counters (stall_cnt_o, drain_cnt_o).
module issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 2,
    parameter int TOT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic             reg1_read_i,
    input  logic [AW-1:0]    reg1_addr_i,
    input  logic             reg2_read_i,
    input  logic [AW-1:0]    reg2_addr_i,
    input  logic             wreg_i,
    input  logic [AW-1:0]    wd_i,
    input  logic             wb_we_i,
    input  logic [AW-1:0]    wb_wd_i,
    input  logic             sync_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic [TOT_W-1:0] inflight_o,
    output logic             err_o
`ifdef ISSUE_SB_STATS_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [15:0]      drain_cnt_o
`endif
);

    localparam logic [AW-1:0]    R0       = {AW{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TOT_W-1:0] TOT_ZERO = {TOT_W{1'b0}};
    localparam logic [TOT_W-1:0] TOT_ONE  = {{(TOT_W-1){1'b0}}, 1'b1};
    localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   pend_r [NREG];
    logic [TOT_W-1:0]   inflight_r;
    logic               err_r;

    logic [CNT_W-1:0]   p1_s;
    logic [CNT_W-1:0]   p2_s;
    logic [CNT_W-1:0]   pw_s;
    logic [CNT_W-1:0]   pb_s;
    logic               hazard_s;
    logic               issue_s;
    logic               stall_s;
    logic               inc_s;
    logic               dec_s;
    logic               bad_wb_s;

    // Look up the pending counts of every addressed register; r0 reads as zero.
    always_comb begin
        p1_s = CNT_ZERO;
        p2_s = CNT_ZERO;
        pw_s = CNT_ZERO;
        pb_s = CNT_ZERO;
        for (int i = 1; i < NREG; i++) begin
            p1_s = (reg1_addr_i == AW'(i)) ? pend_r[i] : p1_s;
            p2_s = (reg2_addr_i == AW'(i)) ? pend_r[i] : p2_s;
            pw_s = (wd_i        == AW'(i)) ? pend_r[i] : pw_s;
            pb_s = (wb_wd_i     == AW'(i)) ? pend_r[i] : pb_s;
        end
    end

    // Hazard detection, issue decision and counter update enables.
    // Registered counts only: a writeback releases a register one cycle later.
    always_comb begin
        hazard_s = (reg1_read_i && (reg1_addr_i != R0) && (p1_s != CNT_ZERO))
                || (reg2_read_i && (reg2_addr_i != R0) && (p2_s != CNT_ZERO))
                || (wreg_i && (wd_i != R0) && (pw_s == CNT_MAX))
                || (wreg_i && (inflight_r == TOT_MAX));
        issue_s  = id_valid_i && (state_r == ST_RUN) && !sync_i && !hazard_s;
        stall_s  = id_valid_i && !issue_s;
        inc_s    = issue_s && wreg_i && (wd_i != R0);
        dec_s    = wb_we_i && (wb_wd_i != R0) && (pb_s != CNT_ZERO);
        bad_wb_s = wb_we_i && (wb_wd_i != R0) && (pb_s == CNT_ZERO);
    end

    // Next-state logic for the run/drain controller.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (sync_i) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (inflight_r == TOT_ZERO) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: state_nx_s = ST_RUN;
        endcase
    end

    // State register for the run/drain controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Per-register pending counters; a simultaneous issue and release cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                pend_r[i] <= CNT_ZERO;
            end
        end else begin
            pend_r[0] <= CNT_ZERO;
            for (int i = 1; i < NREG; i++) begin
                if (inc_s && (wd_i == AW'(i)) && !(dec_s && (wb_wd_i == AW'(i)))) begin
                    pend_r[i] <= pend_r[i] + CNT_ONE;
                end else if (dec_s && (wb_wd_i == AW'(i)) && !(inc_s && (wd_i == AW'(i)))) begin
                    pend_r[i] <= pend_r[i] - CNT_ONE;
                end
            end
        end
    end

    // Total in-flight counter and sticky error on writeback without a pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_r <= TOT_ZERO;
            err_r      <= 1'b0;
        end else begin
            if (inc_s && !dec_s) begin
                inflight_r <= inflight_r + TOT_ONE;
            end else if (dec_s && !inc_s) begin
                inflight_r <= inflight_r - TOT_ONE;
            end
            if (bad_wb_s) begin
                err_r <= 1'b1;
            end
        end
    end

`ifdef ISSUE_SB_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [15:0] drain_cnt_r;

    // Saturating counters of stalled cycles and RUN->DRAIN transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 32'h0000_0000;
            drain_cnt_r <= 16'h0000;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
            end
            if ((state_r == ST_RUN) && sync_i && (drain_cnt_r != 16'hFFFF)) begin
                drain_cnt_r <= drain_cnt_r + 16'h0001;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign drain_cnt_o = drain_cnt_r;
`endif

    // Issue/stall are forced low while reset is held; the rest come from registers.
    assign issue_o    = rst && issue_s;
    assign stall_o    = rst && stall_s;
    assign busy_o     = (state_r == ST_DRAIN);
    assign inflight_o = inflight_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural scoreboard model (per-register pending counts as plain ints).
module tb_issue_scoreboard;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid_i, reg1_read_i, reg2_read_i, wreg_i, wb_we_i, sync_i;
    logic [AW-1:0] reg1_addr_i, reg2_addr_i, wd_i, wb_wd_i;
    logic          issue_o, stall_o, busy_o, err_o;
    logic [3:0]    inflight_o;
`ifdef ISSUE_SB_STATS_EN
    logic [31:0]   stall_cnt_o;
    logic [15:0]   drain_cnt_o;
`endif

    int tests = 0;
    int fails = 0;

    // model state
    int m_pend [NREG];
    int m_infl;
    bit m_drain;
    bit m_err;
    int m_stall;
    int m_drains;

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
        .reg1_read_i(reg1_read_i), .reg1_addr_i(reg1_addr_i),
        .reg2_read_i(reg2_read_i), .reg2_addr_i(reg2_addr_i),
        .wreg_i(wreg_i), .wd_i(wd_i), .wb_we_i(wb_we_i), .wb_wd_i(wb_wd_i),
        .sync_i(sync_i), .issue_o(issue_o), .stall_o(stall_o), .busy_o(busy_o),
        .inflight_o(inflight_o), .err_o(err_o)
`ifdef ISSUE_SB_STATS_EN
        , .stall_cnt_o(stall_cnt_o), .drain_cnt_o(drain_cnt_o)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare DUT against the model each negedge, then advance the model to
    // the state it must hold after the next rising edge.
    always @(negedge clk) begin : cmp
        bit hz, ei, es, dc;
        int old_infl;
        if (!rst) begin
            for (int i = 0; i < NREG; i++) m_pend[i] = 0;
            m_infl = 0; m_drain = 1'b0; m_err = 1'b0; m_stall = 0; m_drains = 0;
            chk("rst_issue", 32'(issue_o), 32'd0);
            chk("rst_stall", 32'(stall_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_inflight", 32'(inflight_o), 32'd0);
            chk("rst_err", 32'(err_o), 32'd0);
        end else begin
            hz = (reg1_read_i && reg1_addr_i != 0 && m_pend[reg1_addr_i] > 0)
              || (reg2_read_i && reg2_addr_i != 0 && m_pend[reg2_addr_i] > 0)
              || (wreg_i && wd_i != 0 && m_pend[wd_i] == 3)
              || (wreg_i && m_infl == 15);
            ei = id_valid_i && !m_drain && !sync_i && !hz;
            es = id_valid_i && !ei;
            chk("issue", 32'(issue_o), 32'(ei));
            chk("stall", 32'(stall_o), 32'(es));
            chk("busy", 32'(busy_o), 32'(m_drain));
            chk("inflight", 32'(inflight_o), 32'(m_infl));
            chk("err", 32'(err_o), 32'(m_err));
`ifdef ISSUE_SB_STATS_EN
            chk("stall_cnt", stall_cnt_o, 32'(m_stall));
            chk("drain_cnt", 32'(drain_cnt_o), 32'(m_drains));
`endif
            old_infl = m_infl;
            dc = wb_we_i && wb_wd_i != 0 && m_pend[wb_wd_i] > 0;
            if (wb_we_i && wb_wd_i != 0 && m_pend[wb_wd_i] == 0) m_err = 1'b1;
            if (dc) begin
                m_pend[wb_wd_i] = m_pend[wb_wd_i] - 1;
                m_infl = m_infl - 1;
            end
            if (ei && wreg_i && wd_i != 0) begin
                m_pend[wd_i] = m_pend[wd_i] + 1;
                m_infl = m_infl + 1;
            end
            if (es) m_stall = m_stall + 1;
            if (!m_drain) begin
                if (sync_i) m_drains = m_drains + 1;
                m_drain = sync_i;
            end else begin
                m_drain = (old_infl != 0);
            end
        end
    end

    task automatic drv(input bit idv, input bit r1, input int a1, input bit r2, input int a2,
                       input bit wr, input int d, input bit wb, input int wbd, input bit sy);
        @(posedge clk);
        #2;
        id_valid_i  = idv;
        reg1_read_i = r1;  reg1_addr_i = AW'(a1);
        reg2_read_i = r2;  reg2_addr_i = AW'(a2);
        wreg_i      = wr;  wd_i        = AW'(d);
        wb_we_i     = wb;  wb_wd_i     = AW'(wbd);
        sync_i      = sy;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #2;
        chk("rstp_issue", 32'(issue_o), 32'd0);
        chk("rstp_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        id_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        id_valid_i = 1'b0; reg1_read_i = 1'b0; reg2_read_i = 1'b0; wreg_i = 1'b0;
        wb_we_i = 1'b0; sync_i = 1'b0;
        reg1_addr_i = '0; reg2_addr_i = '0; wd_i = '0; wb_wd_i = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // 1: independent stream
        drv(1, 1, 0, 1, 4, 1, 1, 0, 0, 0); #2 chk("t1_issue_a", 32'(issue_o), 32'd1);
        drv(1, 1, 0, 1, 4, 1, 2, 0, 0, 0); #2 chk("t1_issue_b", 32'(issue_o), 32'd1);
        drv(1, 1, 0, 1, 4, 1, 3, 0, 0, 0); #2 chk("t1_issue_c", 32'(issue_o), 32'd1);
        chk("t1_infl2", 32'(inflight_o), 32'd2);
        idle(); #2 chk("t1_infl3", 32'(inflight_o), 32'd3);
        do_reset();

        // 2: RAW
        drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); #2 chk("t2_issue", 32'(issue_o), 32'd1);
        drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #2 chk("t2_stall_a", 32'(stall_o), 32'd1);
        drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #2 chk("t2_stall_b", 32'(stall_o), 32'd1);
        drv(1, 1, 5, 0, 0, 0, 0, 1, 5, 0); #2 chk("t2_stall_wb", 32'(stall_o), 32'd1);
        drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #2 chk("t2_issue_after", 32'(issue_o), 32'd1);
        chk("t2_infl0", 32'(inflight_o), 32'd0);
        do_reset();

        // 3: WAW saturation
        for (int k = 0; k < 3; k++) begin
            drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); #2 chk("t3_issue", 32'(issue_o), 32'd1);
        end
        drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); #2 chk("t3_stall", 32'(stall_o), 32'd1);
        chk("t3_infl3", 32'(inflight_o), 32'd3);
        drv(1, 0, 0, 0, 0, 1, 7, 1, 7, 0); #2 chk("t3_stall_wb", 32'(stall_o), 32'd1);
        drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); #2 chk("t3_issue4", 32'(issue_o), 32'd1);
        chk("t3_infl2", 32'(inflight_o), 32'd2);
        idle(); #2 chk("t3_infl3b", 32'(inflight_o), 32'd3);
        do_reset();

        // 4: same-cycle issue and writeback on one register
        drv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 1, 9, 1, 9, 0); #2 chk("t4_issue", 32'(issue_o), 32'd1);
        idle(); #2 chk("t4_infl1", 32'(inflight_o), 32'd1);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        idle(); #2 chk("t4_infl0", 32'(inflight_o), 32'd0);
        chk("t4_err", 32'(err_o), 32'd0);
        do_reset();

        // 5: sync drains two pending writes
        drv(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); #2 chk("t5_sync_noissue", 32'(issue_o), 32'd0);
        chk("t5_sync_stall", 32'(stall_o), 32'd1);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2 chk("t5_busy_a", 32'(busy_o), 32'd1);
        chk("t5_noissue", 32'(issue_o), 32'd0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 10, 0); #2 chk("t5_busy_b", 32'(busy_o), 32'd1);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 11, 0); #2 chk("t5_infl1", 32'(inflight_o), 32'd1);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2 chk("t5_busy_c", 32'(busy_o), 32'd1);
        chk("t5_infl0", 32'(inflight_o), 32'd0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2 chk("t5_run", 32'(busy_o), 32'd0);
        chk("t5_resume", 32'(issue_o), 32'd1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2 chk("t5_z_busy", 32'(busy_o), 32'd1);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2 chk("t5_z_issue", 32'(issue_o), 32'd1);
        do_reset();

        // 6: spurious writeback, then reset in the middle of a drain
        drv(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        idle(); #2 chk("t6_err", 32'(err_o), 32'd1);
        idle(); #2 chk("t6_err_held", 32'(err_o), 32'd1);
        drv(1, 0, 0, 0, 0, 1, 12, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2 chk("t6_busy", 32'(busy_o), 32'd1);
        chk("t6_infl1", 32'(inflight_o), 32'd1);
        @(posedge clk); #2 rst = 1'b0;
        #2 chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_infl", 32'(inflight_o), 32'd0);
        chk("t6_rst_err", 32'(err_o), 32'd0);
        chk("t6_rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #2 rst = 1'b1;

        // randomized traffic on a narrow register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if (n % 300 == 299) begin
                do_reset();
            end else begin
                drv($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 15),
                    $urandom_range(0, 9) < 4, $urandom_range(0, 15),
                    $urandom_range(0, 99) < 3);
            end
        end
        idle();
        @(posedge clk);
        #6;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
